regfile_write_arbiter: RTL and testbench

Shares the single write port of the 8-entry × 8-bit register file between two writeback requesters, for example ALU writeback and memory load. Requests are accepted with a valid/ready handshake under round-robin arbitration. The accepted write is registered into a one-entry output stage that drives the register file's enable/address/data write port. The block also flags read-after-write hazards on the two register-file read addresses while a write is still in flight.

---
 rtl/regfile_write_arbiter_pkg.sv | 18 +
 rtl/regfile_write_arbiter_if.sv | 60 ++++++
 rtl/regfile_write_arbiter_rr_arbiter2.sv | 42 ++++
 rtl/regfile_write_arbiter.sv | 75 +++++++
 tb/tb_regfile_write_arbiter.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter.
//   REG_ADDR_W : register address width (8 registers)
//   DATA_W     : register data width
//   NUM_REGS   : number of registers in the attached register file
//   wr_cmd_t   : one write command {valid, addr, data}; also the output-stage layout
package regfile_write_arbiter_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int DATA_W     = 8;
  localparam int NUM_REGS   = 8;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wr_cmd_t;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Bus interface of the register-file write arbiter.
// master : the environment (two writeback requesters, the register-file write
//          port and the read-address side); slave : the arbiter itself.
//   req0_*/req1_*         : write requests, valid/ready handshake
//   wr_hold               : downstream stall
//   wr_enable/register/data : register-file write port
//   rd_reg1/rd_reg2       : register-file read addresses
//   hazard1/hazard2       : read address hits the in-flight write
//   fwd1_data/fwd2_data   : bypass data, only with REGWR_FORWARD_EN
//   dbg_prio              : round-robin pointer (0 = requester 0 has priority)
//
// Handshake: a request transfers in every cycle where valid and ready are both
// high. Ready is combinational, never high without valid, and at most one of
// the two readies is high per cycle. A requester keeps reg/data stable while
// valid is high and ready is low; it may drop valid before ready.
import regfile_write_arbiter_pkg::*;

interface regfile_write_arbiter_if;
  logic                  req0_valid;
  logic                  req0_ready;
  logic [REG_ADDR_W-1:0] req0_reg;
  logic [DATA_W-1:0]     req0_data;
  logic                  req1_valid;
  logic                  req1_ready;
  logic [REG_ADDR_W-1:0] req1_reg;
  logic [DATA_W-1:0]     req1_data;
  logic                  wr_hold;
  logic                  wr_enable;
  logic [REG_ADDR_W-1:0] wr_register;
  logic [DATA_W-1:0]     wr_data;
  logic [REG_ADDR_W-1:0] rd_reg1;
  logic [REG_ADDR_W-1:0] rd_reg2;
  logic                  hazard1;
  logic                  hazard2;
`ifdef REGWR_FORWARD_EN
  logic [DATA_W-1:0]     fwd1_data;
  logic [DATA_W-1:0]     fwd2_data;
`endif
  logic                  dbg_prio;

  modport master (
    output req0_valid, req0_reg, req0_data, req1_valid, req1_reg, req1_data,
           wr_hold, rd_reg1, rd_reg2,
    input  req0_ready, req1_ready, wr_enable, wr_register, wr_data,
           hazard1, hazard2, dbg_prio
`ifdef REGWR_FORWARD_EN
    , fwd1_data, fwd2_data
`endif
  );

  modport slave (
    input  req0_valid, req0_reg, req0_data, req1_valid, req1_reg, req1_data,
           wr_hold, rd_reg1, rd_reg2,
    output req0_ready, req1_ready, wr_enable, wr_register, wr_data,
           hazard1, hazard2, dbg_prio
`ifdef REGWR_FORWARD_EN
    , fwd1_data, fwd2_data
`endif
  );
endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter with a one-bit priority pointer.
//   clock, reset : clock and synchronous active-high reset
//   en           : arbitration allowed this cycle (grant is suppressed otherwise)
//   req[1:0]     : request vector
//   gnt[1:0]     : one-hot (or zero) grant, combinational
//   prio         : current pointer; 0 means requester 0 wins a tie
// The pointer moves to the non-granted requester on every grant.
import regfile_write_arbiter_pkg::*;

module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       prio
);

  logic prio_q, prio_d;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      if (req == 2'b11) gnt = prio_q ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  always_comb begin
    prio_d = prio_q;
    if (gnt[0])      prio_d = 1'b1;
    else if (gnt[1]) prio_d = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) prio_q <= 1'b0;
    else       prio_q <= prio_d;
  end

  assign prio = prio_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the single write port of an 8 x 8 register file between two
// writeback requesters. Accepted writes land in a one-entry output stage that
// drives the write port one cycle later; read addresses matching the staged
// write raise hazard flags.
//   clock, reset : clock and synchronous active-high reset
//   bus          : regfile_write_arbiter_if.slave (requests, write port,
//                  read addresses, hazards, optional bypass data, dbg_prio)
// Build option: define REGWR_FORWARD_EN to add fwd1_data/fwd2_data bypass
// outputs; without it only the hazard flags are produced.
import regfile_write_arbiter_pkg::*;

module regfile_write_arbiter (
  input logic                   clock,
  input logic                   reset,
  regfile_write_arbiter_if.slave bus
);

  wr_cmd_t    stage_q, stage_d;
  logic       can_accept;
  logic [1:0] gnt;
  logic       prio;

  // The stage can take a new write when empty or when its write commits now.
  // Reset blocks acceptance so no handshake completes into a clearing stage.
  assign can_accept = !reset && (!stage_q.valid || !bus.wr_hold);

  rr_arbiter2 u_arb (
    .clock (clock),
    .reset (reset),
    .en    (can_accept),
    .req   ({bus.req1_valid, bus.req0_valid}),
    .gnt   (gnt),
    .prio  (prio)
  );

  assign bus.req0_ready = gnt[0];
  assign bus.req1_ready = gnt[1];

  always_comb begin
    stage_d = stage_q;
    if (gnt[0]) begin
      stage_d.valid = 1'b1;
      stage_d.addr  = bus.req0_reg;
      stage_d.data  = bus.req0_data;
    end else if (gnt[1]) begin
      stage_d.valid = 1'b1;
      stage_d.addr  = bus.req1_reg;
      stage_d.data  = bus.req1_data;
    end else if (can_accept) begin
      // Drained with nothing new: only the valid bit clears, addr/data stay.
      stage_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) stage_q <= '0;
    else       stage_q <= stage_d;
  end

  assign bus.wr_enable   = stage_q.valid && !bus.wr_hold;
  assign bus.wr_register = stage_q.addr;
  assign bus.wr_data     = stage_q.data;

  // Hazards cover held writes and the cycle in which the write commits.
  assign bus.hazard1 = stage_q.valid && (stage_q.addr == bus.rd_reg1);
  assign bus.hazard2 = stage_q.valid && (stage_q.addr == bus.rd_reg2);

`ifdef REGWR_FORWARD_EN
  assign bus.fwd1_data = bus.hazard1 ? stage_q.data : '0;
  assign bus.fwd2_data = bus.hazard2 ? stage_q.data : '0;
`endif

  assign bus.dbg_prio = prio;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
import regfile_write_arbiter_pkg::*;

module tb_regfile_write_arbiter;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  regfile_write_arbiter_if bus ();

  regfile_write_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Register file fed by the DUT write port.
  logic [DATA_W-1:0] rf_dut [NUM_REGS];
  logic              rf_clr = 1'b1;
  always @(posedge clock) begin
    if (rf_clr) begin
      for (int i = 0; i < NUM_REGS; i++) rf_dut[i] <= '0;
    end else if (bus.wr_enable) begin
      rf_dut[bus.wr_register] <= bus.wr_data;
    end
  end

  // Scoreboard: accepted writes not yet committed, {addr, data}.
  logic [REG_ADDR_W+DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0]            rf_model [NUM_REGS];

  // ---------------- driver tasks ----------------
  task automatic drive_idle();
    bus.req0_valid = 1'b0; bus.req0_reg = '0; bus.req0_data = '0;
    bus.req1_valid = 1'b0; bus.req1_reg = '0; bus.req1_data = '0;
    bus.wr_hold    = 1'b0;
    bus.rd_reg1    = '0;   bus.rd_reg2  = '0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    rf_clr = 1'b1;
    drive_idle();
    repeat (2) @(posedge clock);
    #1;
    reset  = 1'b0;
    rf_clr = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    bus.req0_valid = 1'b1; bus.req0_reg = 3'd1;
    bus.req1_valid = 1'b1; bus.req1_reg = 3'd2;
    @(negedge clock);
    vectors++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin
      miscompares++;
      $display("FAIL reset_ready: got %b expected 00", {bus.req1_ready, bus.req0_ready});
    end
    next_cycle();
    reset = 1'b0; rf_clr = 1'b0;
    drive_idle();
    @(negedge clock);
    vectors++;
    if ({bus.wr_enable, bus.wr_register, bus.wr_data} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_wr: got %h expected 000", {bus.wr_enable, bus.wr_register, bus.wr_data});
    end
    vectors++;
    if ({bus.hazard1, bus.hazard2, bus.dbg_prio} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_haz_prio: got %b expected 000", {bus.hazard1, bus.hazard2, bus.dbg_prio});
    end
`ifdef REGWR_FORWARD_EN
    vectors++;
    if ({bus.fwd1_data, bus.fwd2_data} !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_fwd: got %h expected 0000", {bus.fwd1_data, bus.fwd2_data});
    end
`endif
    next_cycle();
  endtask

  task automatic test_single();
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_reg = 3'd3; bus.req0_data = 8'h5a;
    @(negedge clock);
    vectors++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL single_ready: got %b expected 01", {bus.req1_ready, bus.req0_ready});
    end
    next_cycle();
    drive_idle();
    @(negedge clock);
    vectors++;
    if ({bus.wr_enable, bus.wr_register, bus.wr_data} !== {1'b1, 3'd3, 8'h5a}) begin
      miscompares++;
      $display("FAIL single_write: got %h expected %h", {bus.wr_enable, bus.wr_register, bus.wr_data}, {1'b1, 3'd3, 8'h5a});
    end
    next_cycle();
    @(negedge clock);
    vectors++;
    if (bus.wr_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL single_drain: got %b expected 0", bus.wr_enable);
    end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    int n0 = 0, n1 = 0;
    logic [REG_ADDR_W+DATA_W-1:0] prev = '0;
    logic have_prev = 1'b0;
    logic [1:0] exp_rdy;
    do_reset();
    for (int c = 0; c < 4; c++) begin
      bus.req0_valid = 1'b1; bus.req0_reg = 3'(n0);     bus.req0_data = 8'(8'h10 + n0);
      bus.req1_valid = 1'b1; bus.req1_reg = 3'(4 + n1); bus.req1_data = 8'(8'h20 + n1);
      @(negedge clock);
      exp_rdy = (c % 2 == 0) ? 2'b01 : 2'b10;
      vectors++;
      if ({bus.req1_ready, bus.req0_ready} !== exp_rdy) begin
        miscompares++;
        $display("FAIL rr_grant[%0d]: got %b expected %b", c, {bus.req1_ready, bus.req0_ready}, exp_rdy);
      end
      if (have_prev) begin
        vectors++;
        if ({bus.wr_enable, bus.wr_register, bus.wr_data} !== {1'b1, prev}) begin
          miscompares++;
          $display("FAIL rr_write[%0d]: got %h expected %h", c, {bus.wr_enable, bus.wr_register, bus.wr_data}, {1'b1, prev});
        end
      end
      if (c % 2 == 0) begin prev = {3'(n0), 8'(8'h10 + n0)}; n0++; end
      else            begin prev = {3'(4 + n1), 8'(8'h20 + n1)}; n1++; end
      have_prev = 1'b1;
      next_cycle();
    end
    drive_idle();
    @(negedge clock);
    vectors++;
    if ({bus.wr_enable, bus.wr_register, bus.wr_data} !== {1'b1, prev}) begin
      miscompares++;
      $display("FAIL rr_last_write: got %h expected %h", {bus.wr_enable, bus.wr_register, bus.wr_data}, {1'b1, prev});
    end
    next_cycle();
  endtask

  task automatic test_hold();
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_reg = 3'd5; bus.req0_data = 8'hc3;
    @(negedge clock);
    vectors++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL hold_accept: got %b expected 01", {bus.req1_ready, bus.req0_ready});
    end
    next_cycle();
    bus.wr_hold = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_reg = 3'd1; bus.req0_data = 8'h44;
    bus.req1_valid = 1'b1; bus.req1_reg = 3'd6; bus.req1_data = 8'h66;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      vectors++;
      if ({bus.wr_enable, bus.req1_ready, bus.req0_ready} !== 3'b000) begin
        miscompares++;
        $display("FAIL hold_stall[%0d]: got %b expected 000", k, {bus.wr_enable, bus.req1_ready, bus.req0_ready});
      end
      vectors++;
      if ({bus.wr_register, bus.wr_data} !== {3'd5, 8'hc3}) begin
        miscompares++;
        $display("FAIL hold_stage[%0d]: got %h expected %h", k, {bus.wr_register, bus.wr_data}, {3'd5, 8'hc3});
      end
      next_cycle();
    end
    bus.wr_hold = 1'b0;
    @(negedge clock);
    vectors++;
    if ({bus.wr_enable, bus.wr_register, bus.wr_data, bus.req1_ready, bus.req0_ready} !== {1'b1, 3'd5, 8'hc3, 2'b10}) begin
      miscompares++;
      $display("FAIL hold_release: got %h expected %h", {bus.wr_enable, bus.wr_register, bus.wr_data, bus.req1_ready, bus.req0_ready}, {1'b1, 3'd5, 8'hc3, 2'b10});
    end
    next_cycle();
    bus.req1_valid = 1'b0;
    @(negedge clock);
    vectors++;
    if ({bus.wr_enable, bus.wr_register, bus.wr_data, bus.req1_ready, bus.req0_ready} !== {1'b1, 3'd6, 8'h66, 2'b01}) begin
      miscompares++;
      $display("FAIL hold_next: got %h expected %h", {bus.wr_enable, bus.wr_register, bus.wr_data, bus.req1_ready, bus.req0_ready}, {1'b1, 3'd6, 8'h66, 2'b01});
    end
    next_cycle();
    drive_idle();
    @(negedge clock);
    vectors++;
    if ({bus.wr_enable, bus.wr_register, bus.wr_data} !== {1'b1, 3'd1, 8'h44}) begin
      miscompares++;
      $display("FAIL hold_last: got %h expected %h", {bus.wr_enable, bus.wr_register, bus.wr_data}, {1'b1, 3'd1, 8'h44});
    end
    next_cycle();
  endtask

  task automatic test_hazard();
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_reg = 3'd2; bus.req0_data = 8'h6b;
    bus.rd_reg1 = 3'd2; bus.rd_reg2 = 3'd4;
    @(negedge clock);
    vectors++;
    if ({bus.hazard1, bus.hazard2} !== 2'b00) begin
      miscompares++;
      $display("FAIL haz_unstaged: got %b expected 00", {bus.hazard1, bus.hazard2});
    end
    next_cycle();
    bus.req0_valid = 1'b0;
    bus.wr_hold = 1'b1;
    @(negedge clock);
    vectors++;
    if ({bus.hazard1, bus.hazard2} !== 2'b10) begin
      miscompares++;
      $display("FAIL haz_one: got %b expected 10", {bus.hazard1, bus.hazard2});
    end
`ifdef REGWR_FORWARD_EN
    vectors++;
    if ({bus.fwd1_data, bus.fwd2_data} !== {8'h6b, 8'h00}) begin
      miscompares++;
      $display("FAIL haz_fwd: got %h expected 6b00", {bus.fwd1_data, bus.fwd2_data});
    end
`endif
    next_cycle();
    bus.rd_reg2 = 3'd2;
    @(negedge clock);
    vectors++;
    if ({bus.hazard1, bus.hazard2} !== 2'b11) begin
      miscompares++;
      $display("FAIL haz_held_both: got %b expected 11", {bus.hazard1, bus.hazard2});
    end
    next_cycle();
    bus.wr_hold = 1'b0;
    @(negedge clock);
    vectors++;
    if ({bus.wr_enable, bus.hazard1, bus.hazard2} !== 3'b111) begin
      miscompares++;
      $display("FAIL haz_commit: got %b expected 111", {bus.wr_enable, bus.hazard1, bus.hazard2});
    end
    next_cycle();
    @(negedge clock);
    vectors++;
    if ({bus.hazard1, bus.hazard2} !== 2'b00) begin
      miscompares++;
      $display("FAIL haz_cleared: got %b expected 00", {bus.hazard1, bus.hazard2});
    end
    next_cycle();
  endtask

  task automatic test_same_reg();
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_reg = 3'd7; bus.req0_data = 8'h11;
    bus.req1_valid = 1'b1; bus.req1_reg = 3'd7; bus.req1_data = 8'h22;
    @(negedge clock);
    vectors++;
    if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL same_first: got %b expected 01", {bus.req1_ready, bus.req0_ready});
    end
    next_cycle();
    bus.req0_valid = 1'b0;
    @(negedge clock);
    vectors++;
    if ({bus.wr_enable, bus.wr_register, bus.wr_data, bus.req1_ready} !== {1'b1, 3'd7, 8'h11, 1'b1}) begin
      miscompares++;
      $display("FAIL same_second: got %h expected %h", {bus.wr_enable, bus.wr_register, bus.wr_data, bus.req1_ready}, {1'b1, 3'd7, 8'h11, 1'b1});
    end
    next_cycle();
    bus.req1_valid = 1'b0;
    repeat (2) next_cycle();
    vectors++;
    if (rf_dut[7] !== 8'h22) begin
      miscompares++;
      $display("FAIL same_final: got %h expected 22", rf_dut[7]);
    end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    bus.req0_valid = 1'b1; bus.req0_reg = 3'd4; bus.req0_data = 8'h9e;
    next_cycle();
    drive_idle();
    bus.wr_hold = 1'b1;
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    bus.wr_hold = 1'b0;
    bus.rd_reg1 = 3'd4;
    @(negedge clock);
    vectors++;
    if ({bus.wr_enable, bus.wr_register, bus.wr_data} !== 12'h000) begin
      miscompares++;
      $display("FAIL rst_flight_wr: got %h expected 000", {bus.wr_enable, bus.wr_register, bus.wr_data});
    end
    vectors++;
    if ({bus.hazard1, bus.hazard2, bus.dbg_prio} !== 3'b000) begin
      miscompares++;
      $display("FAIL rst_flight_state: got %b expected 000", {bus.hazard1, bus.hazard2, bus.dbg_prio});
    end
    next_cycle();
    vectors++;
    if (rf_dut[4] !== 8'h00) begin
      miscompares++;
      $display("FAIL rst_flight_rf: got %h expected 00", rf_dut[4]);
    end
  endtask

  task automatic test_random();
    logic v0 = 1'b0, v1 = 1'b0;
    logic [REG_ADDR_W-1:0] r0 = '0, r1 = '0;
    logic [DATA_W-1:0] d0 = '0, d1 = '0;
    int g;
    int last_served = 1;   // requester 0 wins the first tie after reset
    logic [1:0] exp_rdy;
    logic exp_we;
    logic [REG_ADDR_W+DATA_W-1:0] head;
    logic [REG_ADDR_W-1:0] head_reg;
    logic [DATA_W-1:0] head_data;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < NUM_REGS; i++) rf_model[i] = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      // A pending request stays put or is withdrawn; otherwise a fresh one may start.
      if (v0) begin
        if ($urandom_range(0, 7) == 0) v0 = 1'b0;
      end else begin
        v0 = ($urandom_range(0, 2) != 0);
        r0 = 3'($urandom_range(0, 7)); d0 = 8'($urandom_range(0, 255));
      end
      if (v1) begin
        if ($urandom_range(0, 7) == 0) v1 = 1'b0;
      end else begin
        v1 = ($urandom_range(0, 2) != 0);
        r1 = 3'($urandom_range(0, 7)); d1 = 8'($urandom_range(0, 255));
      end
      bus.req0_valid = v0; bus.req0_reg = r0; bus.req0_data = d0;
      bus.req1_valid = v1; bus.req1_reg = r1; bus.req1_data = d1;
      bus.wr_hold = ($urandom_range(0, 3) == 0);
      bus.rd_reg1 = 3'($urandom_range(0, 7));
      bus.rd_reg2 = 3'($urandom_range(0, 7));
      @(negedge clock);

      g = -1;
      if (exp_q.size() == 0 || !bus.wr_hold) begin
        if (v0 && v1)  g = (last_served == 0) ? 1 : 0;
        else if (v0)   g = 0;
        else if (v1)   g = 1;
      end
      exp_rdy = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
      exp_we  = (exp_q.size() != 0) && !bus.wr_hold;
      head    = (exp_q.size() != 0) ? exp_q[0] : '0;
      head_reg  = head[REG_ADDR_W+DATA_W-1:DATA_W];
      head_data = head[DATA_W-1:0];

      vectors++;
      if ({bus.req1_ready, bus.req0_ready} !== exp_rdy) begin
        miscompares++;
        $display("FAIL rnd_ready[%0d]: got %b expected %b", cyc, {bus.req1_ready, bus.req0_ready}, exp_rdy);
      end
      vectors++;
      if (bus.wr_enable !== exp_we) begin
        miscompares++;
        $display("FAIL rnd_we[%0d]: got %b expected %b", cyc, bus.wr_enable, exp_we);
      end
      if (exp_we) begin
        vectors++;
        if ({bus.wr_register, bus.wr_data} !== head) begin
          miscompares++;
          $display("FAIL rnd_wdata[%0d]: got %h expected %h", cyc, {bus.wr_register, bus.wr_data}, head);
        end
      end
      vectors++;
      if ({bus.hazard1, bus.hazard2} !== {(exp_q.size() != 0) && (head_reg == bus.rd_reg1),
                                          (exp_q.size() != 0) && (head_reg == bus.rd_reg2)}) begin
        miscompares++;
        $display("FAIL rnd_hazard[%0d]: got %b staged=%0d reg=%0d rd1=%0d rd2=%0d", cyc,
                 {bus.hazard1, bus.hazard2}, exp_q.size(), head_reg, bus.rd_reg1, bus.rd_reg2);
      end
`ifdef REGWR_FORWARD_EN
      vectors++;
      if ({bus.fwd1_data, bus.fwd2_data} !==
          {((exp_q.size() != 0) && (head_reg == bus.rd_reg1)) ? head_data : 8'h00,
           ((exp_q.size() != 0) && (head_reg == bus.rd_reg2)) ? head_data : 8'h00}) begin
        miscompares++;
        $display("FAIL rnd_fwd[%0d]: got %h staged data %h", cyc, {bus.fwd1_data, bus.fwd2_data}, head_data);
      end
`endif

      @(posedge clock);
      if (exp_we) begin
        rf_model[head_reg] = head_data;
        void'(exp_q.pop_front());
      end
      if (g == 0) begin exp_q.push_back({r0, d0}); v0 = 1'b0; last_served = 0; end
      if (g == 1) begin exp_q.push_back({r1, d1}); v1 = 1'b0; last_served = 1; end
      #1;
    end
    // Let the last staged write commit, then compare the whole register file.
    drive_idle();
    while (exp_q.size() != 0) begin
      head = exp_q.pop_front();
      rf_model[head[REG_ADDR_W+DATA_W-1:DATA_W]] = head[DATA_W-1:0];
    end
    repeat (2) next_cycle();
    for (int i = 0; i < NUM_REGS; i++) begin
      vectors++;
      if (rf_dut[i] !== rf_model[i]) begin
        miscompares++;
        $display("FAIL rnd_rf[%0d]: got %h expected %h", i, rf_dut[i], rf_model[i]);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    drive_idle();
    test_reset();
    test_single();
    test_back_to_back();
    test_hold();
    test_hazard();
    test_same_reg();
    test_reset_inflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
